// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and the counter saturation helper for regfile_scoreboard
//
// Contents:
//   XLEN_DEFAULT / NREG_DEFAULT / AW_DEFAULT : default geometry of the register file
//   ZERO_WORD                                : all-zero data word of default width
//   reg_addr_t / word_t                      : address and data word types at the default geometry
//   sat_limit(cnt_w)                         : largest value a cnt_w-bit pending-write counter may hold
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] word_t;

    localparam word_t ZERO_WORD = '0;

    function automatic int sat_limit(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// rtl/regfile_scoreboard_sb_counter.sv - one saturating pending-write counter of the scoreboard
//
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   inc         : reserve request for this register (ignored while full)
//   dec         : release request for this register (ignored while zero)
//   clr         : flush; clears the counter, wins over inc/dec
//   cnt         : current number of outstanding writes
//   full        : cnt is at the saturation limit
//   underflow   : a release arrived while cnt is zero (combinational pulse)
module sb_counter
    import regfile_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             underflow
);

    localparam int               LIMIT_I = sat_limit(CNT_W);
    localparam logic [CNT_W-1:0] LIMIT   = LIMIT_I[CNT_W-1:0];

    logic inc_ok;
    logic dec_ok;

    assign full      = (cnt == LIMIT);
    assign inc_ok    = inc & ~full;
    assign dec_ok    = dec & (cnt != '0);
    // An unmatched release is an error even on a flush cycle; the flush
    // cannot make a write that was never reserved legitimate.
    assign underflow = dec & (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            unique case ({inc_ok, dec_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with per-register pending-write scoreboard
//
// Optional feature macro: REGFILE_BYPASS_EN (writeback-to-read bypass of data and busy).
//
// Ports:
//   clk, rst_n             : rising-edge clock, asynchronous active-low reset
//   rs1_addr/rs2_addr      : read addresses (decode)
//   rs1_data/rs2_data      : combinational read data, x0 reads as zero
//   rs1_busy/rs2_busy      : read register has an outstanding write
//   rsv_en/rsv_addr        : reserve a destination at issue
//   rsv_full               : counter of rsv_addr saturated, reserve refused
//   wb_en/wb_addr/wb_data  : writeback, also releases one pending write
//   flush                  : clears all pending counters
//   sb_err                 : sticky, a writeback arrived with no pending write
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_full,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            sb_err
);

    logic [XLEN-1:0]  regs  [NREG];
    logic [CNT_W-1:0] cnt_a [NREG];
    logic [NREG-1:0]  full_v;
    logic [NREG-1:0]  unf_v;

    // Register storage; entry 0 is never written so it stays at its reset zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // x0 has no counter: it is never busy, never full and never underflows.
    assign cnt_a[0]  = '0;
    assign full_v[0] = 1'b0;
    assign unf_v[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (rsv_en && (rsv_addr == AW'(r))),
            .dec       (wb_en && (wb_addr == AW'(r))),
            .clr       (flush),
            .cnt       (cnt_a[r]),
            .full      (full_v[r]),
            .underflow (unf_v[r])
        );
    end

    assign rsv_full = full_v[rsv_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (|unf_v) begin
            sb_err <= 1'b1;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        rs1_busy = (cnt_a[rs1_addr] != '0);
        rs2_busy = (cnt_a[rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
        // A writeback in flight to the read register is forwarded; if it
        // retires the last pending write the register is no longer busy.
        if (wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0)) begin
            rs1_data = wb_data;
            if (cnt_a[rs1_addr] == CNT_W'(1)) begin
                rs1_busy = 1'b0;
            end
        end
        if (wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0)) begin
            rs2_data = wb_data;
            if (cnt_a[rs2_addr] == CNT_W'(1)) begin
                rs2_busy = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard with a pending-write reference model
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int NREG  = 32;
    localparam int CNT_W = 2;
    localparam int LIM   = (1 << CNT_W) - 1;

    logic      clk = 1'b0;
    logic      rst_n;
    reg_addr_t rs1_addr, rs2_addr, rsv_addr, wb_addr;
    word_t     rs1_data, rs2_data, wb_data;
    logic      rs1_busy, rs2_busy, rsv_en, rsv_full, wb_en, flush, sb_err;

    regfile_scoreboard #(
        .XLEN  (32),
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_full (rsv_full),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flush    (flush),
        .sb_err   (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t d1;
        word_t d2;
        logic  b1;
        logic  b2;
        logic  full;
        logic  err;
        int    id;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    // Reference model: architectural values, number of writes still owed to
    // each register, and whether an unowed write has ever been seen.
    word_t m_reg [NREG];
    int    m_owed[NREG];
    bit    m_err;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        foreach (m_reg[i]) begin
            m_reg[i]  = '0;
            m_owed[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_step(input bit re, input int ra, input bit we, input int wa,
                                       input word_t wd, input bit fl);
        bit take;
        bit give;
        take = re && (ra != 0) && (m_owed[ra] < LIM);
        give = we && (wa != 0) && (m_owed[wa] > 0);
        if (we && (wa != 0)) begin
            m_reg[wa] = wd;
            if (m_owed[wa] == 0) m_err = 1'b1;
        end
        if (fl) begin
            foreach (m_owed[i]) m_owed[i] = 0;
        end else begin
            if (take) m_owed[ra] = m_owed[ra] + 1;
            if (give) m_owed[wa] = m_owed[wa] - 1;
        end
    endfunction

    function automatic void expect_read(input int a, input bit we, input int wa, input word_t wd,
                                        output word_t d, output logic b);
        d = (a == 0) ? ZERO_WORD : m_reg[a];
        b = (a != 0) && (m_owed[a] != 0);
`ifdef REGFILE_BYPASS_EN
        if (we && (wa == a) && (a != 0)) begin
            d = wd;
            if (m_owed[a] == 1) b = 1'b0;
        end
`endif
    endfunction

    // Called and returns at posedge+1; drives one cycle of stimulus.
    task automatic cycle(input bit re, input int ra, input bit we, input int wa, input word_t wd,
                         input bit fl, input int a1, input int a2);
        exp_t e;
        rsv_en   = re;
        rsv_addr = reg_addr_t'(ra);
        wb_en    = we;
        wb_addr  = reg_addr_t'(wa);
        wb_data  = wd;
        flush    = fl;
        rs1_addr = reg_addr_t'(a1);
        rs2_addr = reg_addr_t'(a2);
        expect_read(a1, we, wa, wd, e.d1, e.b1);
        expect_read(a2, we, wa, wd, e.d2, e.b2);
        e.full = (ra != 0) && (m_owed[ra] == LIM);
        e.err  = m_err;
        e.id   = cyc;
        cyc++;
        q.push_back(e);
        @(posedge clk);
        model_step(re, ra, we, wa, wd, fl);
        #1;
    endtask

    task automatic idle(input int a1, input int a2);
        cycle(0, 0, 0, 0, '0, 0, a1, a2);
    endtask

    // Asserts reset away from any edge and checks outputs before the next edge.
    task automatic reset_check(input int a1, input int a2, input int ra);
        rsv_en   = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
        rs1_addr = reg_addr_t'(a1);
        rs2_addr = reg_addr_t'(a2);
        rsv_addr = reg_addr_t'(ra);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset rs1_data", rs1_data, '0);
        chk("reset rs2_data", rs2_data, '0);
        chk("reset rs1_busy", rs1_busy, '0);
        chk("reset rs2_busy", rs2_busy, '0);
        chk("reset rsv_full", rsv_full, '0);
        chk("reset sb_err", sb_err, '0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, NREG - 1));
        return int'($urandom_range(0, 7));
    endfunction

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("rs1_data#%0d", e.id), rs1_data, e.d1);
                chk($sformatf("rs2_data#%0d", e.id), rs2_data, e.d2);
                chk($sformatf("rs1_busy#%0d", e.id), rs1_busy, e.b1);
                chk($sformatf("rs2_busy#%0d", e.id), rs2_busy, e.b2);
                chk($sformatf("rsv_full#%0d", e.id), rsv_full, e.full);
                chk($sformatf("sb_err#%0d", e.id), sb_err, e.err);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rsv_en   = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
        rsv_addr = '0;
        wb_addr  = '0;
        wb_data  = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle(5, 3);

        // Asynchronous reset with a pending write and stored data in x5.
        cycle(1, 5, 0, 0, '0, 0, 5, 0);
        cycle(1, 5, 1, 5, 32'h0000_1234, 0, 5, 5);
        idle(5, 5);
        reset_check(5, 5, 5);

        // x0 ignores writes and reserves.
        cycle(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        cycle(1, 0, 0, 0, '0, 0, 0, 0);
        idle(0, 0);

        // Reserve twice, release twice.
        cycle(1, 3, 0, 0, '0, 0, 3, 0);
        cycle(1, 3, 0, 0, '0, 0, 3, 0);
        cycle(0, 3, 1, 3, 32'h1111_0001, 0, 3, 3);
        idle(3, 3);
        cycle(0, 3, 1, 3, 32'h2222_0002, 0, 3, 3);
        idle(3, 3);

        // Saturation of x7.
        repeat (3) cycle(1, 7, 0, 0, '0, 0, 7, 0);
        cycle(1, 7, 0, 0, '0, 0, 7, 0);
        repeat (3) cycle(0, 7, 1, 7, $urandom, 0, 7, 7);
        idle(7, 7);

        // Simultaneous reserve/release, flush, then an unowed release.
        cycle(1, 4, 0, 0, '0, 0, 4, 0);
        cycle(1, 4, 1, 4, 32'h4444_0004, 0, 4, 4);
        idle(4, 4);
        cycle(1, 4, 0, 0, '0, 1, 4, 4);
        idle(4, 4);
        cycle(0, 0, 1, 4, 32'h4444_0005, 0, 4, 4);
        idle(4, 4);

        // Writeback while the consumer reads the same register.
        reset_check(9, 9, 9);
        cycle(1, 9, 0, 0, '0, 0, 0, 9);
        cycle(0, 9, 1, 9, 32'hA5A5_A5A5, 0, 0, 9);
        idle(0, 9);

        // Random traffic in blocks, each ended by a mid-cycle reset.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 200; i++) begin
                cycle(bit'($urandom_range(0, 1)), pick(),
                      ($urandom_range(0, 9) < 4), pick(), $urandom,
                      ($urandom_range(0, 31) == 0), pick(), pick());
            end
            reset_check(pick(), pick(), pick());
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
